mem_bus_ctrl: RTL

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// CPU MEM-stage to external bus bridge: one outstanding transfer, IDLE -> REQ -> DONE.
// Optional bus timeout with sticky error is enabled by defining MEMBUS_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_memread,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e state;
  logic   req_any;

  assign req_any   = cpu_memread | cpu_memwrite;
  assign cpu_ready = ((state == StIdle) && !req_any) || (state == StDone);

  // Byte lane bits never reach the word-addressed bus.
  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = cpu_addr[1:0];

`ifdef MEMBUS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] cnt;
  logic            timeout_hit;

  // Fires on the edge that would complete the TIMEOUT-th REQ cycle.
  assign timeout_hit = (32'(cnt) + 32'd1) >= TIMEOUT;
`else
  logic [63:0] unused_cfg;
  assign unused_cfg = {TIMEOUT, ERR_DATA};
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
`ifdef MEMBUS_TIMEOUT_EN
      cnt       <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (req_any) begin
            bus_addr  <= {cpu_addr[31:2], 2'b00};
            bus_wdata <= cpu_wdata;
            bus_we    <= cpu_memwrite;
            bus_req   <= 1'b1;
            state     <= StReq;
`ifdef MEMBUS_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        StReq: begin
          if (bus_ack) begin
            if (!bus_we) cpu_rdata <= bus_rdata;
            bus_req <= 1'b0;
            state   <= StDone;
          end
`ifdef MEMBUS_TIMEOUT_EN
          else if (timeout_hit) begin
            if (!bus_we) cpu_rdata <= ERR_DATA;
            bus_err <= 1'b1;
            bus_req <= 1'b0;
            state   <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule
